// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts a signed 16-bit value to BCD by serial
// double-dabble and multiplexes sign/hundreds/tens/ones onto a 4-digit
// active-low seven-segment display.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t         state_reg, state_next;
  logic           accept, finish;
  logic [15:0]    bin_reg;
  logic [19:0]    bcd_reg;
  logic [3:0]     step_reg;
  logic           sign_reg;
  logic [15:0]    magnitude;
  logic [19:0]    bcd_adj;
  logic [19:0]    shift_bcd;
  logic [15:0]    shift_bin;

  logic [3:0]     ones_reg, tens_reg, hund_reg;
  logic [3:0]     ones_next, tens_next, hund_next;
  logic           ovf_reg, ovf_next;
  logic           disp_sign_reg, disp_sign_next;
  logic           done_reg;

  logic [CW-1:0]  refresh_reg;
  logic [1:0]     idx_reg;
  logic [6:0]     seg_reg, seg_next;
  logic [3:0]     an_reg, an_next;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'b1000000;
      4'd1:    digit_glyph = 7'b1111001;
      4'd2:    digit_glyph = 7'b0100100;
      4'd3:    digit_glyph = 7'b0110000;
      4'd4:    digit_glyph = 7'b0011001;
      4'd5:    digit_glyph = 7'b0010010;
      4'd6:    digit_glyph = 7'b0000010;
      4'd7:    digit_glyph = 7'b1111000;
      4'd8:    digit_glyph = 7'b0000000;
      4'd9:    digit_glyph = 7'b0010000;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

  // |result| fits in 16 unsigned bits, including -32768 -> 32768
  assign magnitude = result[15] ? (~result + 16'd1) : result;

  // Add-3 correction on every BCD digit that is 5 or more before shifting
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign shift_bcd = (bcd_adj << 1) | {19'd0, bin_reg[15]};
  assign shift_bin = bin_reg << 1;

  // Next-state logic: accept only in IDLE, finish after the 16th shift
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (step_reg == 4'd15) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Conversion datapath: capture on accept, one shift per CONVERT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      step_reg <= '0;
      sign_reg <= 1'b0;
    end else if (accept) begin
      bin_reg  <= magnitude;
      bcd_reg  <= '0;
      step_reg <= '0;
      sign_reg <= result[15];
    end else if (state_reg == CONVERT) begin
      bin_reg  <= shift_bin;
      bcd_reg  <= shift_bcd;
      step_reg <= step_reg + 4'd1;
    end
  end

  // Display values taking effect at this edge (used so seg shows them at once)
  always_comb begin
    ones_next      = ones_reg;
    tens_next      = tens_reg;
    hund_next      = hund_reg;
    ovf_next       = ovf_reg;
    disp_sign_next = disp_sign_reg;
    if (finish) begin
      ones_next      = shift_bcd[3:0];
      tens_next      = shift_bcd[7:4];
      hund_next      = shift_bcd[11:8];
      ovf_next       = |shift_bcd[19:12];
      disp_sign_next = sign_reg;
    end
  end

  // Display registers and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_reg      <= '0;
      tens_reg      <= '0;
      hund_reg      <= '0;
      ovf_reg       <= 1'b0;
      disp_sign_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      ones_reg      <= ones_next;
      tens_reg      <= tens_next;
      hund_reg      <= hund_next;
      ovf_reg       <= ovf_next;
      disp_sign_reg <= disp_sign_next;
      done_reg      <= finish;
    end
  end

  // Free-running refresh divider stepping the scanned digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_reg <= '0;
      idx_reg     <= '0;
    end else if (refresh_reg == CW'(REFRESH_DIV - 1)) begin
      refresh_reg <= '0;
      idx_reg     <= idx_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
    end
  end

  // Glyph selection with leading-zero blanking and overflow dashes
  always_comb begin
    seg_next = GLYPH_BLANK;
    an_next  = ~(4'b0001 << idx_reg);
    case (idx_reg)
      2'd0: seg_next = ovf_next ? GLYPH_DASH : digit_glyph(ones_next);
      2'd1: seg_next = ovf_next ? GLYPH_DASH :
                       ((hund_next == 4'd0 && tens_next == 4'd0) ? GLYPH_BLANK
                                                                 : digit_glyph(tens_next));
      2'd2: seg_next = ovf_next ? GLYPH_DASH :
                       ((hund_next == 4'd0) ? GLYPH_BLANK : digit_glyph(hund_next));
      default: seg_next = disp_sign_next ? GLYPH_DASH : GLYPH_BLANK;
    endcase
  end

  // Registered display drive
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= 7'b1000000;
      an_reg  <= 4'b1110;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign busy     = (state_reg == CONVERT);
  assign done     = done_reg;
  assign overflow = ovf_reg;
  assign seg      = seg_reg;
  assign an       = an_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: table of display vectors, hand sequences
// for busy/done/reset corners, and a randomized run against a cycle model.
module tb_display_scan_ctrl;

  localparam int DIV = 4;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] result = '0;
  logic        busy, done, overflow;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .result(result),
    .busy(busy), .done(done), .overflow(overflow), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference glyphs computed from decimal arithmetic on the displayed value
  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
      default: glyph = BL;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int i, input int v);
    int mag;
    mag = (v < 0) ? -v : v;
    if (i == 3)            return (v < 0) ? DS : BL;
    if (mag > 999)         return DS;
    if (i == 0)            return glyph(mag % 10);
    if (i == 1)            return (mag < 10) ? BL : glyph((mag / 10) % 10);
    return (mag < 100) ? BL : glyph((mag / 100) % 10);
  endfunction

  // Behavioural model: conversion countdown, displayed value, scan time
  int         m_left = 0;
  int         m_pend = 0;
  int         m_disp = 0;
  int         m_t = 0;
  logic       m_done = 1'b0;
  logic [6:0] m_seg = 7'b1000000;
  logic [3:0] m_an = 4'b1110;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_disp <= 0; m_done <= 1'b0; m_t <= 0;
      m_an <= 4'b1110; m_seg <= 7'b1000000;
    end else begin
      m_done <= (m_left == 1);
      if (m_left > 0) m_left <= m_left - 1;
      else if (load) begin
        m_left <= 16;
        m_pend <= int'($signed(result));
      end
      m_disp <= (m_left == 1) ? m_pend : m_disp;
      m_seg  <= model_seg((m_t / DIV) % 4, (m_left == 1) ? m_pend : m_disp);
      m_an   <= ~(4'b0001 << ((m_t / DIV) % 4));
      m_t    <= m_t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_left > 0));
      chk("done", done, m_done);
      chk("overflow", overflow, ((m_disp > 999) || (m_disp < -999)));
      chk("seg", seg, m_seg);
      chk("an", an, m_an);
    end
  end

  typedef struct {
    logic [15:0] val;
    logic [6:0]  s_ones, s_tens, s_hund, s_sign;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load = 1'b1; result = v;
    @(negedge clk);
    load = 1'b0; result = 16'($urandom);
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic capture(output logic [27:0] got);
    got = 'x;
    for (int j = 0; j < 4 * DIV + 2; j++) begin
      case (an)
        4'b1110: got[6:0]   = seg;
        4'b1101: got[13:7]  = seg;
        4'b1011: got[20:14] = seg;
        4'b0111: got[27:21] = seg;
        default: ;
      endcase
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] pick();
    int tmp;
    case ($urandom_range(0, 4))
      0: pick = 16'($urandom);
      1: pick = 16'($urandom_range(0, 999));
      2: begin tmp = $urandom_range(1, 999); pick = 16'(-tmp); end
      3: case ($urandom_range(0, 5))
           0: pick = 16'd0;     1: pick = 16'd999;
           2: pick = 16'd1000;  3: pick = 16'hFC19;
           4: pick = 16'h8000;  default: pick = 16'h7FFF;
         endcase
      default: pick = 16'($urandom_range(0, 99));
    endcase
  endfunction

  initial begin
    int n;
    logic [27:0] got;

    vecs[0] = '{16'd123,  7'b0110000, 7'b0100100, 7'b1111001, BL, 1'b0};
    vecs[1] = '{16'hFFD3, 7'b0010010, 7'b0011001, BL,         DS, 1'b0};
    vecs[2] = '{16'd1000, DS,         DS,         DS,         BL, 1'b1};
    vecs[3] = '{16'h8000, DS,         DS,         DS,         DS, 1'b1};
    vecs[4] = '{16'd0,    7'b1000000, BL,         BL,         BL, 1'b0};
    vecs[5] = '{16'd7,    7'b1111000, BL,         BL,         BL, 1'b0};
    vecs[6] = '{16'hFC19, 7'b0010000, 7'b0010000, 7'b0010000, DS, 1'b0};
    vecs[7] = '{16'd305,  7'b0010010, 7'b1000000, 7'b0110000, BL, 1'b0};

    // Reset and idle scan sequence
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    chk("scan1_an", an, 4'b1101);
    chk("scan1_seg", seg, BL);
    repeat (4) @(negedge clk);
    chk("scan2_an", an, 4'b1011);
    chk("scan2_seg", seg, BL);
    repeat (4) @(negedge clk);
    chk("scan3_an", an, 4'b0111);
    chk("scan3_seg", seg, BL);

    // Table-driven display vectors
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val);
      wait_done(1, n);
      chk($sformatf("latency_%0d", i), n, 17);
      chk($sformatf("ovf_%0d", i), overflow, vecs[i].ovf);
      capture(got);
      chk($sformatf("ones_%0d", i), got[6:0],   vecs[i].s_ones);
      chk($sformatf("tens_%0d", i), got[13:7],  vecs[i].s_tens);
      chk($sformatf("hund_%0d", i), got[20:14], vecs[i].s_hund);
      chk($sformatf("sign_%0d", i), got[27:21], vecs[i].s_sign);
    end

    // Load while busy is dropped; load in the done cycle is taken
    do_load(16'd123);
    repeat (4) @(negedge clk);
    load = 1'b1; result = 16'd7;
    @(negedge clk);
    load = 1'b0;
    wait_done(6, n);
    chk("busy_ignored_latency", n, 17);
    chk("busy_ignored_ovf", overflow, 1'b0);
    load = 1'b1; result = 16'd7;
    @(negedge clk);
    load = 1'b0;
    chk("done_cycle_accept_busy", busy, 1'b1);
    wait_done(1, n);
    chk("done_cycle_latency", n, 17);
    capture(got);
    chk("seven_ones", got[6:0], 7'b1111000);
    chk("seven_tens", got[13:7], BL);
    chk("seven_hund", got[20:14], BL);

    // Reset in the middle of a conversion
    do_load(16'd500);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_an", an, 4'b1110);
    chk("abort_seg", seg, 7'b1000000);
    n = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);

    // Randomized traffic against the model
    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      load   = ($urandom_range(0, 3) == 0);
      result = pick();
      rst    = ($urandom_range(0, 80) == 0);
    end
    @(negedge clk);
    load = 1'b0; rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
